// File: rtl/sync_fifo_cfg.sv
// sync_fifo_cfg: single-clock FIFO with arbitrary depth (>= 2), programmable
// almost-full/almost-empty thresholds, an occupancy count, overflow/underflow
// pulses and a selectable standard or first-word-fall-through read port.
module sync_fifo_cfg #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 1,
    parameter int FWFT       = 0,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rinc,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_WIDTH = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_AF   = CNT_WIDTH'(AF_LEVEL);
    localparam logic [CNT_WIDTH-1:0] CNT_AE   = CNT_WIDTH'(AE_LEVEL);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [0:FIFO_DEPTH-1];
    logic [PTR_WIDTH-1:0]  wptr_q, wptr_d;
    logic [PTR_WIDTH-1:0]  rptr_q, rptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  overflow_q, underflow_q;
    logic                  wr_acc, rd_acc;

    // Flags are pure decodes of the count register, so they only move after an edge.
    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Accept decisions and next pointer/count values; pointers wrap by compare
    // so non-power-of-two depths work.
    always_comb begin
        wr_acc  = winc & ~full;
        rd_acc  = rinc & ~empty;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_acc) begin
            wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_ONE;
        end
        if (rd_acc) begin
            rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_ONE;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage array; deliberately not reset, writes are blocked during reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Pointer, count and protocol-violation pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= winc & full;
            underflow_q <= rinc & empty;
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [DATA_WIDTH-1:0] rdata_q;
            logic                  rvalid_q;

            // Registered read port: data loads on an accepted pop and holds otherwise.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) begin
                        rdata_q <= mem_q[rptr_q];
                    end
                end
            end

            assign rdata  = rdata_q;
            assign rvalid = rvalid_q;
        end else begin : g_fwft
            // Head word is presented directly; rinc acknowledges it.
            assign rdata  = mem_q[rptr_q];
            assign rvalid = ~empty;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_cfg.sv
// tb_sync_fifo_cfg: three instances (depth 8 standard read, depth 8 FWFT,
// depth 5 standard read) checked against queue-based reference models.
module tb_sync_fifo_cfg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Instance A: depth 8, standard read
    logic       a_winc = 0, a_rinc = 0;
    logic [7:0] a_wdata = 0, a_rdata;
    logic       a_rvalid, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [3:0] a_count;
    // Instance B: depth 8, FWFT
    logic       b_winc = 0, b_rinc = 0;
    logic [7:0] b_wdata = 0, b_rdata;
    logic       b_rvalid, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [3:0] b_count;
    // Instance C: depth 5, standard read
    logic       c_winc = 0, c_rinc = 0;
    logic [7:0] c_wdata = 0, c_rdata;
    logic       c_rvalid, c_full, c_empty, c_af, c_ae, c_ovf, c_udf;
    logic [2:0] c_count;

    sync_fifo_cfg #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) u_a (
        .clk(clk), .rst(rst), .winc(a_winc), .wdata(a_wdata), .rinc(a_rinc),
        .rdata(a_rdata), .rvalid(a_rvalid), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_udf));

    sync_fifo_cfg #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)) u_b (
        .clk(clk), .rst(rst), .winc(b_winc), .wdata(b_wdata), .rinc(b_rinc),
        .rdata(b_rdata), .rvalid(b_rvalid), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_udf));

    sync_fifo_cfg #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_c (
        .clk(clk), .rst(rst), .winc(c_winc), .wdata(c_wdata), .rinc(c_rinc),
        .rdata(c_rdata), .rvalid(c_rvalid), .full(c_full), .empty(c_empty),
        .almost_full(c_af), .almost_empty(c_ae), .count(c_count),
        .overflow(c_ovf), .underflow(c_udf));

    // Reference model state: contents as queues plus expected read-port/pulse values.
    logic [7:0] qa[$], qb[$], qc[$];
    logic [7:0] ea_rd = 0, ec_rd = 0, dummy;
    logic       ea_rv = 0, ea_ovf = 0, ea_udf = 0;
    logic       eb_ovf = 0, eb_udf = 0;
    logic       ec_rv = 0, ec_ovf = 0, ec_udf = 0;

    // One clock: model follows the requests seen at the rising edge; returns at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            qa.delete(); qb.delete(); qc.delete();
            ea_rd = 0; ea_rv = 0; ea_ovf = 0; ea_udf = 0;
            eb_ovf = 0; eb_udf = 0;
            ec_rd = 0; ec_rv = 0; ec_ovf = 0; ec_udf = 0;
        end else begin
            ea_ovf = a_winc && (qa.size() == 8);
            ea_udf = a_rinc && (qa.size() == 0);
            ea_rv  = 1'b0;
            if (a_rinc && qa.size() != 0) begin ea_rd = qa.pop_front(); ea_rv = 1'b1; end
            if (a_winc && !ea_ovf) qa.push_back(a_wdata);

            eb_ovf = b_winc && (qb.size() == 8);
            eb_udf = b_rinc && (qb.size() == 0);
            if (b_rinc && qb.size() != 0) dummy = qb.pop_front();
            if (b_winc && !eb_ovf) qb.push_back(b_wdata);

            ec_ovf = c_winc && (qc.size() == 5);
            ec_udf = c_rinc && (qc.size() == 0);
            ec_rv  = 1'b0;
            if (c_rinc && qc.size() != 0) begin ec_rd = qc.pop_front(); ec_rv = 1'b1; end
            if (c_winc && !ec_ovf) qc.push_back(c_wdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if ({a_count, a_empty, a_full, a_ae, a_af} !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL reset_a_flags got cnt=%0d e=%b f=%b ae=%b af=%b exp cnt=0 e=1 f=0 ae=1 af=0",
                               a_count, a_empty, a_full, a_ae, a_af); end
        checks++; if ({a_rvalid, a_ovf, a_udf, a_rdata} !== 11'd0) begin
            errors++; $display("FAIL reset_a_port got rv=%b ovf=%b udf=%b rd=%h exp all 0", a_rvalid, a_ovf, a_udf, a_rdata); end
        checks++; if ({b_empty, b_rvalid, c_empty, c_count} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
            errors++; $display("FAIL reset_bc got b_e=%b b_rv=%b c_e=%b c_cnt=%0d exp 1 0 1 0", b_empty, b_rvalid, c_empty, c_count); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            a_winc = 1'b1; a_wdata = 8'(i);
            tick();
            checks++; if (a_count !== 4'(i)) begin
                errors++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, a_count, i); end
            checks++; if ({a_empty, a_ae, a_af, a_full} !== {1'b0, (i <= 1), (i >= 6), (i == 8)}) begin
                errors++; $display("FAIL fill_flags i=%0d got e/ae/af/f=%b%b%b%b exp=%b%b%b%b", i, a_empty, a_ae, a_af, a_full,
                                   1'b0, (i <= 1), (i >= 6), (i == 8)); end
        end
        a_wdata = 8'h09;
        tick();
        a_winc = 1'b0;
        checks++; if ({a_ovf, a_count} !== {1'b1, 4'd8}) begin
            errors++; $display("FAIL fill_overflow got ovf=%b cnt=%0d exp ovf=1 cnt=8", a_ovf, a_count); end
        tick();
        checks++; if (a_ovf !== 1'b0) begin
            errors++; $display("FAIL fill_ovf_pulse got=%b exp=0", a_ovf); end
    endtask

    task automatic test_drain_std();
        for (int i = 1; i <= 8; i++) begin
            a_rinc = 1'b1;
            tick();
            checks++; if ({a_rvalid, a_rdata} !== {1'b1, 8'(i)}) begin
                errors++; $display("FAIL drain_data i=%0d got rv=%b rd=%h exp rv=1 rd=%h", i, a_rvalid, a_rdata, 8'(i)); end
        end
        checks++; if (a_empty !== 1'b1) begin
            errors++; $display("FAIL drain_empty got=%b exp=1", a_empty); end
        a_rinc = 1'b0;
        tick();
        checks++; if ({a_rvalid, a_rdata} !== {1'b0, 8'h08}) begin
            errors++; $display("FAIL drain_hold got rv=%b rd=%h exp rv=0 rd=08", a_rvalid, a_rdata); end
        a_rinc = 1'b1;
        tick();
        a_rinc = 1'b0;
        checks++; if ({a_udf, a_rvalid, a_rdata} !== {1'b1, 1'b0, 8'h08}) begin
            errors++; $display("FAIL drain_underflow got udf=%b rv=%b rd=%h exp 1 0 08", a_udf, a_rvalid, a_rdata); end
        tick();
        checks++; if (a_udf !== 1'b0) begin
            errors++; $display("FAIL drain_udf_pulse got=%b exp=0", a_udf); end
    endtask

    task automatic test_fwft();
        b_winc = 1'b1; b_wdata = 8'hA5;
        tick();
        b_winc = 1'b0;
        checks++; if ({b_rvalid, b_rdata, b_empty} !== {1'b1, 8'hA5, 1'b0}) begin
            errors++; $display("FAIL fwft_show got rv=%b rd=%h e=%b exp rv=1 rd=a5 e=0", b_rvalid, b_rdata, b_empty); end
        tick();
        checks++; if ({b_rvalid, b_rdata} !== {1'b1, 8'hA5}) begin
            errors++; $display("FAIL fwft_hold got rv=%b rd=%h exp rv=1 rd=a5", b_rvalid, b_rdata); end
        b_rinc = 1'b1;
        tick();
        b_rinc = 1'b0;
        checks++; if ({b_rvalid, b_empty} !== {1'b0, 1'b1}) begin
            errors++; $display("FAIL fwft_pop got rv=%b e=%b exp rv=0 e=1", b_rvalid, b_empty); end
        b_winc = 1'b1; b_wdata = 8'h11; tick();
        b_wdata = 8'h22; tick();
        b_winc = 1'b0;
        checks++; if (b_rdata !== 8'h11) begin
            errors++; $display("FAIL fwft_head got=%h exp=11", b_rdata); end
        b_rinc = 1'b1; tick();
        b_rinc = 1'b0;
        checks++; if ({b_rvalid, b_rdata, b_count} !== {1'b1, 8'h22, 4'd1}) begin
            errors++; $display("FAIL fwft_next got rv=%b rd=%h cnt=%0d exp 1 22 1", b_rvalid, b_rdata, b_count); end
        b_rinc = 1'b1; tick();
        b_rinc = 1'b0;
    endtask

    task automatic test_wrap_simul();
        logic [7:0] exp_d;
        for (int i = 0; i < 3; i++) begin
            c_winc = 1'b1; c_wdata = 8'h30 + 8'(i);
            tick();
        end
        c_winc = 1'b0;
        checks++; if (c_count !== 3'd3) begin
            errors++; $display("FAIL wrap_start got cnt=%0d exp=3", c_count); end
        for (int k = 0; k < 20; k++) begin
            c_winc = 1'b1; c_rinc = 1'b1; c_wdata = 8'h40 + 8'(k);
            tick();
            exp_d = (k < 3) ? 8'h30 + 8'(k) : 8'h40 + 8'(k - 3);
            checks++; if ({c_count, c_rvalid, c_rdata} !== {3'd3, 1'b1, exp_d}) begin
                errors++; $display("FAIL wrap_cycle k=%0d got cnt=%0d rv=%b rd=%h exp cnt=3 rv=1 rd=%h",
                                   k, c_count, c_rvalid, c_rdata, exp_d); end
        end
        c_winc = 1'b0; c_rinc = 1'b0;
    endtask

    task automatic test_boundary();
        for (int i = 0; i < 8; i++) begin
            a_winc = 1'b1; a_wdata = 8'h20 + 8'(i); tick();
        end
        a_wdata = 8'h99; a_rinc = 1'b1;
        tick();
        a_winc = 1'b0; a_rinc = 1'b0;
        checks++; if ({a_ovf, a_count, a_rvalid, a_rdata} !== {1'b1, 4'd7, 1'b1, 8'h20}) begin
            errors++; $display("FAIL full_simul got ovf=%b cnt=%0d rv=%b rd=%h exp 1 7 1 20", a_ovf, a_count, a_rvalid, a_rdata); end
        for (int i = 0; i < 7; i++) begin
            a_rinc = 1'b1; tick();
            checks++; if (a_rdata !== 8'h21 + 8'(i)) begin
                errors++; $display("FAIL full_drain i=%0d got=%h exp=%h", i, a_rdata, 8'h21 + 8'(i)); end
        end
        a_winc = 1'b1; a_wdata = 8'h5A;
        tick();
        a_winc = 1'b0; a_rinc = 1'b0;
        checks++; if ({a_udf, a_count, a_rvalid} !== {1'b1, 4'd1, 1'b0}) begin
            errors++; $display("FAIL empty_simul got udf=%b cnt=%0d rv=%b exp 1 1 0", a_udf, a_count, a_rvalid); end
        for (int i = 0; i < 3; i++) begin
            a_winc = 1'b1; a_wdata = 8'h61 + 8'(i); tick();
        end
        checks++; if (a_count !== 4'd4) begin
            errors++; $display("FAIL mid_rst_pre got cnt=%0d exp=4", a_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0; a_winc = 1'b0;
        checks++; if ({a_count, a_empty, a_rvalid, a_ovf, a_rdata} !== {4'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++; $display("FAIL mid_rst got cnt=%0d e=%b rv=%b ovf=%b rd=%h exp 0 1 0 0 00",
                               a_count, a_empty, a_rvalid, a_ovf, a_rdata); end
        for (int i = 0; i < 8; i++) begin
            a_winc = 1'b1; a_wdata = 8'h70 + 8'(i); tick();
        end
        rst = 1'b1;
        tick();
        checks++; if ({a_ovf, a_full, a_count} !== {1'b0, 1'b0, 4'd0}) begin
            errors++; $display("FAIL rst_full_winc got ovf=%b f=%b cnt=%0d exp 0 0 0", a_ovf, a_full, a_count); end
        a_winc = 1'b0; a_rinc = 1'b1;
        tick();
        rst = 1'b0; a_rinc = 1'b0;
        checks++; if (a_udf !== 1'b0) begin
            errors++; $display("FAIL rst_empty_rinc got udf=%b exp=0", a_udf); end
    endtask

    task automatic test_random();
        int pw, pr;
        for (int n = 0; n < 400; n++) begin
            pw = (n < 100) ? 70 : (n < 200) ? 30 : 50;
            pr = 100 - pw;
            rst     = ($urandom_range(0, 99) == 0);
            a_winc  = ($urandom_range(0, 99) < pw); a_rinc = ($urandom_range(0, 99) < pr); a_wdata = 8'($urandom);
            b_winc  = ($urandom_range(0, 99) < pw); b_rinc = ($urandom_range(0, 99) < pr); b_wdata = 8'($urandom);
            c_winc  = ($urandom_range(0, 99) < pw); c_rinc = ($urandom_range(0, 99) < pr); c_wdata = 8'($urandom);
            tick();
            checks++; if ({a_count, a_rdata} !== {4'(qa.size()), ea_rd}) begin
                errors++; $display("FAIL rnd_a_data n=%0d got cnt=%0d rd=%h exp cnt=%0d rd=%h", n, a_count, a_rdata, qa.size(), ea_rd); end
            checks++; if ({a_full, a_empty, a_af, a_ae, a_ovf, a_udf, a_rvalid} !==
                          {(qa.size() == 8), (qa.size() == 0), (qa.size() >= 6), (qa.size() <= 1), ea_ovf, ea_udf, ea_rv}) begin
                errors++; $display("FAIL rnd_a_flags n=%0d got f/e/af/ae/ovf/udf/rv=%b%b%b%b%b%b%b exp=%b%b%b%b%b%b%b", n,
                                   a_full, a_empty, a_af, a_ae, a_ovf, a_udf, a_rvalid, (qa.size() == 8), (qa.size() == 0),
                                   (qa.size() >= 6), (qa.size() <= 1), ea_ovf, ea_udf, ea_rv); end
            checks++; if ({b_full, b_empty, b_af, b_ae, b_ovf, b_udf, b_rvalid, b_count} !==
                          {(qb.size() == 8), (qb.size() == 0), (qb.size() >= 6), (qb.size() <= 1), eb_ovf, eb_udf,
                           (qb.size() != 0), 4'(qb.size())}) begin
                errors++; $display("FAIL rnd_b_flags n=%0d got f/e/af/ae/ovf/udf/rv=%b%b%b%b%b%b%b cnt=%0d exp cnt=%0d ovf=%b udf=%b",
                                   n, b_full, b_empty, b_af, b_ae, b_ovf, b_udf, b_rvalid, b_count, qb.size(), eb_ovf, eb_udf); end
            if (qb.size() != 0) begin
                checks++; if (b_rdata !== qb[0]) begin
                    errors++; $display("FAIL rnd_b_data n=%0d got=%h exp=%h", n, b_rdata, qb[0]); end
            end
            checks++; if ({c_count, c_rdata} !== {3'(qc.size()), ec_rd}) begin
                errors++; $display("FAIL rnd_c_data n=%0d got cnt=%0d rd=%h exp cnt=%0d rd=%h", n, c_count, c_rdata, qc.size(), ec_rd); end
            checks++; if ({c_full, c_empty, c_af, c_ae, c_ovf, c_udf, c_rvalid} !==
                          {(qc.size() == 5), (qc.size() == 0), (qc.size() >= 3), (qc.size() <= 1), ec_ovf, ec_udf, ec_rv}) begin
                errors++; $display("FAIL rnd_c_flags n=%0d got f/e/af/ae/ovf/udf/rv=%b%b%b%b%b%b%b exp=%b%b%b%b%b%b%b", n,
                                   c_full, c_empty, c_af, c_ae, c_ovf, c_udf, c_rvalid, (qc.size() == 5), (qc.size() == 0),
                                   (qc.size() >= 3), (qc.size() <= 1), ec_ovf, ec_udf, ec_rv); end
        end
        rst = 1'b0;
        a_winc = 1'b0; a_rinc = 1'b0; b_winc = 1'b0; b_rinc = 1'b0; c_winc = 1'b0; c_rinc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_std();
        test_fwft();
        test_wrap_simul();
        test_boundary();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_cfg.md
# sync_fifo_cfg

Single-clock, parametrised FIFO for buffering between blocks that share one clock domain, such as the register file, the ALU result path and the UART TX feeder. It generalises the team's FIFO storage and pointer logic in three ways: it supports any depth ≥ 2, not only powers of two; it adds programmable almost-full and almost-empty thresholds plus an occupancy count; and it offers a selectable first-word-fall-through (FWFT) read mode. It also reports overflow and underflow attempts so upstream logic can detect protocol violations.

## Interface
- DATA_WIDTH, 8, width of each entry
- FIFO_DEPTH, 8, number of entries; must be ≥ 2; need not be a power of two
- AF_LEVEL, FIFO_DEPTH-2, almost_full asserts when count ≥ AF_LEVEL; legal range 1..FIFO_DEPTH
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL; legal range 0..FIFO_DEPTH-1
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word fall-through
- CNT_WIDTH, $clog2(FIFO_DEPTH+1), width of count
- clk  in  1  the single clock; all logic samples on the rising edge
- rst  in  1  synchronous, active-high reset
- winc  in  1  write request
- wdata  in  DATA_WIDTH  write data, sampled when winc is high
- rinc  in  1  read (pop) request
- rdata  out  DATA_WIDTH  read data
- rvalid  out  1  rdata is valid (see Operation)
- full  out  1  count == FIFO_DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  CNT_WIDTH  current occupancy
- overflow  out  1  one-cycle pulse when a write is rejected
- underflow  out  1  one-cycle pulse when a read is rejected

## Operation
- Storage is a FIFO_DEPTH × DATA_WIDTH register array. The array is not reset.
- Write and read pointers are each $clog2(FIFO_DEPTH) bits wide. Each pointer wraps from FIFO_DEPTH-1 to 0 by explicit compare; power-of-two rollover is not relied on.
- A write is accepted when winc is high and full is low: mem[wptr] ← wdata and wptr advances.
- A read is accepted when rinc is high and empty is low: rptr advances.
- Flags are evaluated on the registered state before the edge. On a simultaneous winc and rinc:
  - When full: only the read is accepted, the write is rejected and overflow pulses.
  - When empty: only the write is accepted, the read is rejected and underflow pulses.
  - Otherwise: both are accepted and count is unchanged.
- Count update: +1 for write only, -1 for read only, unchanged for both or neither.
- full, empty, almost_full and almost_empty are combinational decodes of the count register, so they are glitch-free and change only after a clock edge.
- FWFT=0 (standard read mode):
  - rdata is a register loaded with mem[rptr] on an accepted read.
  - rvalid is a registered pulse, high for exactly the one cycle after each accepted read.
  - rdata holds its value between reads.
- FWFT=1 (fall-through read mode):
  - rdata = mem[rptr] combinationally.
  - rvalid = ~empty.
  - rinc acknowledges the word currently presented on rdata.
- Reset (rst high at an edge) takes priority over all other activity:
  - wptr, rptr and count are set to 0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - rvalid=0, overflow=0, underflow=0, rdata=0 (FWFT=0).
  - Any winc or rinc in the reset cycle is ignored and does not cause an overflow or underflow pulse.
  - Reset asserted mid-operation discards all stored entries.

## Timing
- Write-to-read latency:
  - A write at edge N clears empty from cycle N+1.
  - FWFT=1: the word is visible on rdata in cycle N+1.
  - FWFT=0: the earliest rdata update is at edge N+1 (if rinc is high in cycle N+1), and the data is visible with rvalid in cycle N+2.
- Read latency: one cycle (FWFT=0), zero cycles (FWFT=1).
- Full throughput: one write and one read per cycle are sustained indefinitely at any occupancy between 1 and FIFO_DEPTH-1.
- Flag latency: every flag and count reflect all requests accepted up to and including the previous edge.
- overflow and underflow are registered and appear in the cycle after the rejected request.

## Test plan
- Reset and fill (FIFO_DEPTH=8, AF_LEVEL=6, AE_LEVEL=1): write 0x01..0x08 on consecutive cycles.
  - Required: almost_empty drops when count reaches 2; almost_full rises when count reaches 6; full rises at count 8.
  - A 9th write of 0x09 must pulse overflow and leave count at 8.
- Drain with FWFT=0: read the full FIFO back.
  - Required: rdata sequence 0x01..0x08, each with a one-cycle rvalid one cycle after its rinc.
  - empty asserts after the 8th read; a further rinc pulses underflow and rdata holds 0x08.
- FWFT=1: write 0xA5 into an empty FIFO.
  - Required: in the next cycle rdata=0xA5 and rvalid=1 with rinc low.
  - A rinc then empties the FIFO and rvalid drops the following cycle.
- Simultaneous read and write with FIFO_DEPTH=5 (non-power-of-two depth), run for 20 cycles from count=3.
  - Required: count stays at 3 throughout, pointers wrap 4→0 with no gap, and the data order is preserved.
- Boundary and reset:
  - With the FIFO full, assert winc and rinc together: the read is accepted, overflow=1 and count becomes 7.
  - With the FIFO empty, assert winc and rinc together: the write is accepted, underflow=1 and count becomes 1.
  - Assert rst at count=4 with winc high: the next cycle shows count=0, empty=1, rvalid=0 and no overflow pulse.
